// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer and registered in_ready.
// Optional occupancy statistics are enabled with the PIPE_STAGE_STATS_EN macro.
module pipe_stage_skid #(
    parameter int unsigned      WIDTH  = 96,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       occupancy_o,
    output logic [31:0]      stall_cnt_o,
    output logic [15:0]      flush_cnt_o
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [1:0]         occupancy_q, occupancy_d;
    logic               accept;
    logic               take;

    assign accept = in_valid_i & in_ready_q;
    assign take   = out_valid_q & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Any payload accepted this cycle is dropped along with the held entries.
            state_d = StEmpty;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StOne;
                        main_d  = in_data_i;
                    end
                end
                StOne: begin
                    if (accept && take) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        state_d = StTwo;
                        skid_d  = in_data_i;
                    end else if (take) begin
                        state_d = StEmpty;
                        main_d  = BUBBLE;
                    end
                end
                StTwo: begin
                    if (take) begin
                        state_d = StOne;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    // Handshake and status outputs come straight from flops, derived from the next state.
    always_comb begin
        in_ready_d  = (state_d != StTwo);
        out_valid_d = (state_d != StEmpty);
        unique case (state_d)
            StOne:   occupancy_d = 2'd1;
            StTwo:   occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StEmpty;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;
    assign occupancy_o = occupancy_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid_q && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_i && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 16'd0;
`endif

    a_bubble_when_empty: assert property (
        @(posedge clk) disable iff (reset) !out_valid_q |-> (main_q == BUBBLE)
    );
    a_ready_only_when_not_full: assert property (
        @(posedge clk) disable iff (reset) in_ready_q == (state_q != StTwo)
    );
    a_valid_matches_state: assert property (
        @(posedge clk) disable iff (reset) out_valid_q == (state_q != StEmpty)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random checks of pipe_stage_skid against a queue-based reference model.
module tb_pipe_stage_skid;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: an ordered queue of at most two entries plus statistics.
    logic [31:0] q[$];
    logic [31:0] stall_m;
    logic [15:0] flush_m;

    pipe_stage_skid #(
        .WIDTH  (32),
        .BUBBLE (32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .occupancy_o (occupancy),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        stall_m = 32'd0;
        flush_m = 16'd0;
    endfunction

    function automatic void model_step(input logic v, input logic [31:0] d, input logic r,
                                       input logic f);
        bit had;
        bit full;
        had  = (q.size() > 0);
        full = (q.size() == 2);
        if (had && !r && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
        if (f && flush_m != 16'hFFFF) flush_m = flush_m + 16'd1;
        if (f) begin
            q.delete();
        end else begin
            if (had && r) void'(q.pop_front());
            if (v && !full) q.push_back(d);
        end
    endfunction

    task automatic check_model();
        logic [31:0] head;
        head = (q.size() > 0) ? q[0] : 32'h0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("out_data", out_data, head);
        chk("occupancy", {30'd0, occupancy}, q.size());
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
`ifdef PIPE_STAGE_STATS_EN
        chk("stall_cnt", stall_cnt, stall_m);
        chk("flush_cnt", {16'd0, flush_cnt}, {16'd0, flush_m});
`else
        chk("stall_cnt", stall_cnt, 32'd0);
        chk("flush_cnt", {16'd0, flush_cnt}, 32'd0);
`endif
    endtask

    // Drive one cycle's inputs (from a negedge), clock them in, then compare at the next negedge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        model_step(v, d, r, f);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 32'h0;
        out_ready = 1'b0;
        flush = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_model();
    endtask

    initial begin
        reset = 1'b1;
        do_reset();
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_data", out_data, 32'h0);

        // Streaming: one payload per cycle with a one-cycle latency.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, i, 1'b1, 1'b0);
            chk("stream_data", out_data, i);
            chk("stream_occ", {30'd0, occupancy}, 32'd1);
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream_drain", {31'd0, out_valid}, 32'd0);

        // Backpressure: third offer is refused while full, order preserved afterwards.
        cycle(1'b1, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b0, 1'b0);
        chk("bp_occ", {30'd0, occupancy}, 32'd2);
        chk("bp_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_head", out_data, 32'hA);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_out_b", out_data, 32'hB);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        chk("bp_out_c", out_data, 32'hC);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Flush while full with a concurrent offer.
        cycle(1'b1, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b0, 1'b1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_occ", {30'd0, occupancy}, 32'd0);
        chk("flush_data", out_data, 32'h0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_stays_empty", {31'd0, out_valid}, 32'd0);

        // Drain from ONE to EMPTY.
        cycle(1'b1, 32'h5, 1'b0, 1'b0);
        chk("drain_head", out_data, 32'h5);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_data", out_data, 32'h0);

        // Asynchronous reset while full: outputs clear before the next clock edge.
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        chk("pre_reset_occ", {30'd0, occupancy}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("async_rst_occ", {30'd0, occupancy}, 32'd0);
        chk("async_rst_data", out_data, 32'h0);
        do_reset();

        // Statistics: 5 stalled cycles then 2 flush pulses.
        cycle(1'b1, 32'h77, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
`ifdef PIPE_STAGE_STATS_EN
        chk("stats_stall", stall_cnt, 32'd5);
        chk("stats_flush", {16'd0, flush_cnt}, 32'd2);
`else
        chk("stats_stall_off", stall_cnt, 32'd0);
        chk("stats_flush_off", {16'd0, flush_cnt}, 32'd0);
`endif

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register with a valid/ready handshake on both sides. It generalises the fixed-field stall/flush stage registers. It holds a 2-entry skid buffer so that in_ready is driven straight from a flop, allowing backpressure to cut timing paths between stages. Flush inserts a bubble. Used between any two pipeline stages (IF/ID, ID/EX, ...) carrying a packed payload.

Parameters:
WIDTH, 96, payload width in bits (e.g. Instr+PC+PCPlus4 = 96)
BUBBLE, {WIDTH{1'b0}}, payload value presented when the stage is empty or flushed

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of all entries
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept (registered)
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  downstream accepts
out_data  output  WIDTH  head payload (main register)
occupancy  output  2  entries held: 0, 1 or 2
stall_cnt  output  32  cycles with out_valid=1 and out_ready=0 (feature only)
flush_cnt  output  16  flush cycles seen (feature only)

Behaviour:
- Clock, reset and interface: reset reset, asynchronous, active-high; clock clk.
- Definitions: accept = in_valid & in_ready; take = out_valid & out_ready.
- Reset values:
  - state EMPTY; main and skid = BUBBLE.
  - out_valid=0, in_ready=1, occupancy=0, out_data=BUBBLE.
  - Counters = 0.
- State machine, with in_ready a flop equal to (next_state != TWO):
  - EMPTY (out_valid=0):
    - accept -> ONE, main<=in_data.
  - ONE (out_valid=1):
    - accept&take -> ONE, main<=in_data.
    - accept&!take -> TWO, skid<=in_data.
    - !accept&take -> EMPTY, main<=BUBBLE.
    - otherwise hold.
  - TWO (out_valid=1, in_ready=0):
    - take -> ONE, main<=skid, skid<=BUBBLE.
    - otherwise hold. in_valid is ignored.
- Ordering and timing:
  - FIFO order is preserved; the skid entry is never presented before main.
  - Latency: in_data accepted at edge N appears on out_data after edge N (1 cycle) when the stage was EMPTY, or when it was ONE with take.
  - Throughput: 1 payload per cycle when out_ready stays 1.
- Flush (highest priority below reset):
  - Next state EMPTY; main and skid <= BUBBLE; in_ready=1 next cycle.
  - A payload offered with accept in the same cycle is dropped.
  - A take in the same cycle still counts downstream: the output was valid at that edge.
- Register rules:
  - out_data always equals the main register; it is BUBBLE whenever out_valid=0.
  - occupancy = 0/1/2 for EMPTY/ONE/TWO, registered.
- Reset mid-operation: all entries are discarded immediately and asynchronously. No partial payload survives.
- No combinational path from out_ready to in_ready; in_valid/in_data to out_* are also flop-only.

Optional Feature:
PIPE_STAGE_STATS_EN
- Defined:
  - stall_cnt increments every cycle with out_valid=1 & out_ready=0 and saturates at 32'hFFFF_FFFF.
  - flush_cnt increments on every cycle with flush=1 and saturates at 16'hFFFF.
  - Both counters are cleared only by reset.
- Undefined: stall_cnt and flush_cnt are tied to constant 0 and no counter flops exist.

Test Plan:
1. Reset during traffic (state TWO) -> out_valid=0, in_ready=1, occupancy=0, out_data=0 immediately, before the next clock edge.
2. Streaming: in_valid=1, out_ready=1, data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later each; occupancy stays 1; in_ready stays 1.
3. Backpressure: out_ready=0, push 0xA, 0xB, then offer 0xC -> occupancy=2, in_ready=0, 0xC not accepted. Then out_ready=1 -> outputs 0xA, 0xB, 0xC in order.
4. Flush while full (0xA, 0xB held) with in_valid=1 and data 0xC -> next cycle out_valid=0, occupancy=0, out_data=BUBBLE, in_ready=1; 0xA, 0xB and 0xC never appear.
5. Drain to empty: ONE with take and no accept -> out_valid=0 and out_data=BUBBLE the next cycle.
6. With PIPE_STAGE_STATS_EN: 5 stalled cycles plus 2 flush pulses -> stall_cnt=5, flush_cnt=2. Without the macro both read 0.
